// File: rtl/arm_pkg.sv
// Shared processor definitions used by the pipeline stages.
package arm_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues one blocking memory access per load/store,
// stalls upstream while waiting for the acknowledge, and drives register write-back.
module mem_wb_stage
   import arm_pkg::*;
#(
   parameter logic [DATA_W-1:0] MEM_BASE    = 32'd1024,
   parameter int                ACK_TIMEOUT = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic                 wb_en_in,
   input  logic                 mem_r_en_in,
   input  logic                 mem_w_en_in,
   input  logic [DATA_W-1:0]    alu_result_in,
   input  logic [DATA_W-1:0]    st_val_in,
   input  logic [REG_IDX_W-1:0] dest_in,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [DATA_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_ack,
   output logic                 freeze,
   output logic                 mem_err,
   output logic                 writeBackEn,
   output logic [REG_IDX_W-1:0] destWB,
   output logic [DATA_W-1:0]    resultWB
);

   localparam int               CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   mem_state_e            r_state, w_state_next;
   logic [CNT_W-1:0]      r_cnt, w_cnt_next;
   logic                  r_mem_req, w_mem_req_next;
   logic                  r_mem_we, w_mem_we_next;
   logic [DATA_W-1:0]     r_mem_addr, w_mem_addr_next;
   logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_next;
   logic                  r_mem_err, w_mem_err_next;
   logic                  r_wb_en, w_wb_en_next;
   logic [REG_IDX_W-1:0]  r_dest, w_dest_next;
   logic [DATA_W-1:0]     r_result, w_result_next;
   logic                  w_mem_op;
   logic                  w_expire;
   logic                  w_freeze;

   assign w_mem_op = valid_in & (mem_r_en_in | mem_w_en_in);
   assign w_expire = (r_cnt == CNT_LAST);

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_mem_req_next   = r_mem_req;
      w_mem_we_next    = r_mem_we;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_mem_err_next   = 1'b0;
      w_wb_en_next     = 1'b0;
      w_dest_next      = r_dest;
      w_result_next    = r_result;
      w_freeze         = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_mem_op) begin
               // A load wins when both enables are set.
               w_state_next     = ACCESS;
               w_cnt_next       = '0;
               w_mem_req_next   = 1'b1;
               w_mem_we_next    = ~mem_r_en_in;
               w_mem_addr_next  = alu_result_in - MEM_BASE;
               w_mem_wdata_next = st_val_in;
               w_freeze         = 1'b1;
            end else begin
               w_wb_en_next  = valid_in & wb_en_in;
               w_result_next = alu_result_in;
               w_dest_next   = dest_in;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               w_state_next   = IDLE;
               w_mem_req_next = 1'b0;
               if (!r_mem_we) begin
                  w_result_next = mem_rdata;
                  w_dest_next   = dest_in;
                  w_wb_en_next  = wb_en_in;
               end
            end else if (w_expire) begin
               // Abort: upstream is released this cycle and skips the faulting op.
               w_state_next   = IDLE;
               w_mem_req_next = 1'b0;
               w_mem_err_next = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
               w_freeze   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_err   <= 1'b0;
         r_wb_en     <= 1'b0;
         r_dest      <= '0;
         r_result    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_mem_req   <= w_mem_req_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
         r_mem_err   <= w_mem_err_next;
         r_wb_en     <= w_wb_en_next;
         r_dest      <= w_dest_next;
         r_result    <= w_result_next;
      end
   end

   // Reset forces state to IDLE, but inputs may still look like a memory op.
   assign freeze      = w_freeze & ~rst;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_err     = r_mem_err;
   assign writeBackEn = r_wb_en;
   assign destWB      = r_dest;
   assign resultWB    = r_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, load, store, timeout,
// reset mid-access and stray acknowledge.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [31:0] alu_result_in, st_val_in, mem_rdata;
   logic [3:0]  dest_in;
   logic        mem_ack;
   logic        mem_req, mem_we, freeze, mem_err, writeBackEn;
   logic [31:0] mem_addr, mem_wdata, resultWB;
   logic [3:0]  destWB;

   int n_vec = 0;
   int n_err = 0;

   mem_wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .wb_en_in     (wb_en_in),
      .mem_r_en_in  (mem_r_en_in),
      .mem_w_en_in  (mem_w_en_in),
      .alu_result_in(alu_result_in),
      .st_val_in    (st_val_in),
      .dest_in      (dest_in),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .freeze       (freeze),
      .mem_err      (mem_err),
      .writeBackEn  (writeBackEn),
      .destWB       (destWB),
      .resultWB     (resultWB)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_in = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f_cnt;
      int req_cycles;
      logic wb_seen;
      logic last_freeze;

      rst = 1'b1;
      idle_inputs();
      alu_result_in = '0; st_val_in = '0; dest_in = '0;
      mem_rdata = '0; mem_ack = 1'b0;

      // ---------------- reset state
      tick(); tick();
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_mem_we", 32'(mem_we), 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      check_val("rst_mem_err", 32'(mem_err), 32'd0);
      check_val("rst_wben", 32'(writeBackEn), 32'd0);
      check_val("rst_destwb", 32'(destWB), 32'd0);
      check_val("rst_resultwb", resultWB, 32'd0);
      valid_in = 1'b1; mem_r_en_in = 1'b1;
      #2;
      check_val("rst_freeze_memop", 32'(freeze), 32'd0);
      idle_inputs();
      tick();
      rst = 1'b0;
      $display("txn reset done");

      // ---------------- ALU pass-through
      valid_in = 1'b1; wb_en_in = 1'b1; alu_result_in = 32'h55; dest_in = 4'd3;
      #2;
      check_val("alu_freeze_in", 32'(freeze), 32'd0);
      tick();
      idle_inputs();
      #2;
      check_val("alu_wben", 32'(writeBackEn), 32'd1);
      check_val("alu_destwb", 32'(destWB), 32'd3);
      check_val("alu_resultwb", resultWB, 32'h55);
      check_val("alu_freeze_out", 32'(freeze), 32'd0);
      tick();
      check_val("alu_wben_once", 32'(writeBackEn), 32'd0);
      $display("txn alu dest=3 result=55");

      // ---------------- load, ack in 4th ACCESS cycle
      valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
      alu_result_in = 32'd1028; dest_in = 4'd7;
      f_cnt = 0;
      #2;
      if (freeze) f_cnt++;
      tick();
      check_val("ld_mem_req", 32'(mem_req), 32'd1);
      check_val("ld_mem_addr", mem_addr, 32'd4);
      check_val("ld_mem_we", 32'(mem_we), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) begin
            mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
         end
         #2;
         if (freeze) f_cnt++;
         check_val("ld_wben_bubble", 32'(writeBackEn), 32'd0);
         tick();
      end
      mem_ack = 1'b0;
      idle_inputs();
      check_val("ld_freeze_cycles", 32'(f_cnt), 32'd4);
      check_val("ld_wben", 32'(writeBackEn), 32'd1);
      check_val("ld_destwb", 32'(destWB), 32'd7);
      check_val("ld_resultwb", resultWB, 32'hDEADBEEF);
      check_val("ld_req_drop", 32'(mem_req), 32'd0);
      tick();
      check_val("ld_wben_once", 32'(writeBackEn), 32'd0);
      $display("txn load addr=4 data=deadbeef");

      // ---------------- store, immediate ack (wb_en_in set to prove it is ignored)
      valid_in = 1'b1; wb_en_in = 1'b1; mem_w_en_in = 1'b1;
      alu_result_in = 32'd1032; st_val_in = 32'hA5A5A5A5; dest_in = 4'd2;
      f_cnt = 0;
      #2;
      if (freeze) f_cnt++;
      tick();
      mem_ack = 1'b1;
      #2;
      if (freeze) f_cnt++;
      check_val("st_mem_req", 32'(mem_req), 32'd1);
      check_val("st_mem_addr", mem_addr, 32'd8);
      check_val("st_mem_we", 32'(mem_we), 32'd1);
      check_val("st_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      tick();
      mem_ack = 1'b0;
      idle_inputs();
      check_val("st_freeze_cycles", 32'(f_cnt), 32'd1);
      check_val("st_wben", 32'(writeBackEn), 32'd0);
      check_val("st_req_drop", 32'(mem_req), 32'd0);
      tick();
      check_val("st_wben_after", 32'(writeBackEn), 32'd0);
      $display("txn store addr=8 data=a5a5a5a5");

      // ---------------- timeout: load never acknowledged; address wraps below MEM_BASE
      valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
      alu_result_in = 32'd4; dest_in = 4'd5;
      tick();
      check_val("to_mem_addr_wrap", mem_addr, 32'hFFFFFC04);
      req_cycles = 0; wb_seen = 1'b0; last_freeze = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #2;
         if (!mem_req) break;
         req_cycles++;
         if (writeBackEn) wb_seen = 1'b1;
         last_freeze = freeze;
         tick();
      end
      idle_inputs();
      #1;
      check_val("to_req_cycles", 32'(req_cycles), 32'd16);
      check_val("to_last_freeze", 32'(last_freeze), 32'd0);
      check_val("to_mem_err", 32'(mem_err), 32'd1);
      check_val("to_wben", 32'(writeBackEn), 32'd0);
      check_val("to_wb_seen", 32'(wb_seen), 32'd0);
      tick();
      check_val("to_err_once", 32'(mem_err), 32'd0);
      check_val("to_freeze_idle", 32'(freeze), 32'd0);
      check_val("to_req_idle", 32'(mem_req), 32'd0);
      $display("txn load timeout req_cycles=%0d", req_cycles);

      // ---------------- reset two cycles into ACCESS
      valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
      alu_result_in = 32'd1040; dest_in = 4'd6;
      tick();
      tick();
      #2;
      check_val("rm_req_before", 32'(mem_req), 32'd1);
      check_val("rm_freeze_before", 32'(freeze), 32'd1);
      rst = 1'b1;
      #1;
      check_val("rm_req_async", 32'(mem_req), 32'd0);
      check_val("rm_freeze_async", 32'(freeze), 32'd0);
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h00001234; wb_en_in = 1'b1; dest_in = 4'd6;
      tick();
      mem_ack = 1'b0; wb_en_in = 1'b0;
      check_val("rm_late_ack_wben", 32'(writeBackEn), 32'd0);
      check_val("rm_late_ack_req", 32'(mem_req), 32'd0);
      tick();
      check_val("rm_late_ack_wben2", 32'(writeBackEn), 32'd0);
      $display("txn reset mid-access");

      // ---------------- simultaneous read/write is a load; then stray ack in IDLE
      valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
      alu_result_in = 32'd1100; st_val_in = 32'h11112222; dest_in = 4'd9;
      tick();
      check_val("rw_mem_we", 32'(mem_we), 32'd0);
      check_val("rw_mem_addr", mem_addr, 32'd76);
      check_val("rw_mem_req", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
      tick();
      mem_ack = 1'b0;
      idle_inputs();
      check_val("rw_wben", 32'(writeBackEn), 32'd1);
      check_val("rw_resultwb", resultWB, 32'hCAFE0001);
      check_val("rw_destwb", 32'(destWB), 32'd9);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      #2;
      check_val("sa_freeze", 32'(freeze), 32'd0);
      tick();
      mem_ack = 1'b0;
      check_val("sa_wben", 32'(writeBackEn), 32'd0);
      check_val("sa_resultwb", resultWB, 32'd1100);
      check_val("sa_destwb", 32'(destWB), 32'd9);
      check_val("sa_mem_req", 32'(mem_req), 32'd0);
      check_val("sa_mem_we", 32'(mem_we), 32'd0);
      check_val("sa_mem_addr", mem_addr, 32'd76);
      check_val("sa_mem_err", 32'(mem_err), 32'd0);
      $display("txn r/w load plus stray ack");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- MEM_BASE, default 32'd1024: subtracted from the ALU result to form the memory address.
- ACK_TIMEOUT, default 16: maximum number of ACCESS cycles to wait for mem_ack.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk: in, 1. Single clock; all state changes on the rising edge.
- rst: in, 1. Asynchronous, active-high reset.
- valid_in: in, 1. The upstream (EX/MEM) slot holds a real instruction.
- wb_en_in: in, 1. The instruction writes a register.
- mem_r_en_in: in, 1. Load.
- mem_w_en_in: in, 1. Store.
- alu_result_in: in, 32. ALU result or effective address.
- st_val_in: in, 32. Store data.
- dest_in: in, 4. Destination register index.
- mem_req: out, 1. Memory request, held until acknowledged.
- mem_we: out, 1. Write strobe qualifying mem_req.
- mem_addr: out, 32. Memory address.
- mem_wdata: out, 32. Memory write data.
- mem_rdata: in, 32. Read data, valid while mem_ack is high.
- mem_ack: in, 1. Memory completion, one-cycle pulse.
- freeze: out, 1. Stalls all upstream stages.
- mem_err: out, 1. One-cycle pulse on access timeout.
- writeBackEn: out, 1. Register-file write enable.
- destWB: out, 4. Register-file write index.
- resultWB: out, 32. Register-file write data.

REQ-003 Clock and reset SHALL be one clock, clk, and reset rst, asynchronous and active-high.

Function
REQ-004 A memory op SHALL be defined as valid_in & (mem_r_en_in | mem_w_en_in); when both enables are set, the op SHALL be treated as a load (mem_we=0).
REQ-005 The FSM SHALL have two states, IDLE and ACCESS.
REQ-006 Non-memory pass-through: in IDLE with no memory op, the stage SHALL register writeBackEn<=valid_in&wb_en_in, resultWB<=alu_result_in and destWB<=dest_in, giving 1-cycle latency.
REQ-007 IDLE with a memory op SHALL transition to ACCESS at the next edge and register the following on that edge: mem_addr<=alu_result_in-MEM_BASE (32-bit modular), mem_wdata<=st_val_in, mem_we<=~mem_r_en_in, mem_req<=1, timeout counter<=0; writeBackEn<=0 (bubble).
REQ-008 In ACCESS, mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until mem_ack or timeout.
REQ-009 ACCESS with mem_ack=1 SHALL complete the access at that edge: state<=IDLE, mem_req<=0; a load SHALL register resultWB<=mem_rdata, destWB<=dest_in and writeBackEn<=wb_en_in; a store SHALL register writeBackEn<=0.
REQ-010 ACCESS without mem_ack SHALL increment the counter and register writeBackEn<=0.
REQ-011 When the counter reaches ACK_TIMEOUT-1 without mem_ack, the stage SHALL abort: state<=IDLE, mem_req<=0, writeBackEn<=0, mem_err pulses high for one cycle.
REQ-012 freeze SHALL be combinational: (IDLE & memory op) | (ACCESS & ~mem_ack & ~timeout-expiry); on an abort, upstream therefore advances past the faulting instruction.
REQ-013 Upstream inputs SHALL be sampled only while freeze is asserted or in IDLE; the stage relies on them being stable during ACCESS.
REQ-014 mem_ack received in IDLE SHALL be ignored, with no state or output change.
REQ-015 Minimum memory-op latency SHALL be 2 cycles (IDLE detect plus ACCESS with immediate ack); back-to-back memory ops SHALL each take at least 2 cycles.
REQ-016 writeBackEn SHALL be high for exactly one cycle per completed writing instruction, never during a bubble.

Reset
REQ-017 rst SHALL asynchronously force state=IDLE, counter=0, and all outputs to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_err, writeBackEn, destWB, resultWB.
REQ-018 rst during ACCESS SHALL drop mem_req immediately (no edge required) and discard the in-flight access; any later mem_ack SHALL be ignored per REQ-014.
REQ-019 freeze SHALL read 0 while rst is high.

Structure
REQ-020 The state enum (IDLE, ACCESS), DATA_W=32 and REG_IDX_W=4 SHALL live in the shared processor package (arm_pkg); MEM_BASE and ACK_TIMEOUT SHALL remain module parameters.
REQ-021 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline, $clog2(ACK_TIMEOUT) bits wide.

Verification
REQ-022 ALU op: valid_in=1, wb_en_in=1, alu_result_in=32'h55, dest_in=3 -> next cycle writeBackEn=1, destWB=3, resultWB=32'h55; freeze=0 throughout.
REQ-023 Load: alu_result_in=1028, dest_in=7, mem_ack after 3 ACCESS cycles with mem_rdata=32'hDEADBEEF -> mem_addr=4, mem_we=0, freeze high 4 cycles, then writeBackEn=1, destWB=7, resultWB=32'hDEADBEEF for one cycle.
REQ-024 Store: alu_result_in=1032, st_val_in=32'hA5A5A5A5, immediate ack -> mem_addr=8, mem_we=1, mem_wdata=32'hA5A5A5A5, writeBackEn never 1, freeze high 1 cycle.
REQ-025 Timeout: load with no mem_ack -> mem_req high exactly 16 cycles, then mem_err pulses once, freeze drops, writeBackEn stays 0, state returns to IDLE.
REQ-026 Reset mid-access: assert rst 2 cycles into ACCESS -> mem_req and freeze drop without a clock edge; mem_ack pulsed after reset release -> no writeBackEn.
REQ-027 Simultaneous r/w plus stray ack: mem_r_en_in=mem_w_en_in=1 -> mem_we=0 (load); mem_ack pulsed in IDLE -> no output change.
